// File: rtl/mips_register_file_pkg.sv
// Shared CPU datapath types: word and register-select widths used by the register file.
package cpu_types_pkg;
  localparam int WORD_W = 32;
  localparam int REG_W  = 5;
  localparam int NREGS  = 1 << REG_W;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;
endpackage

// File: rtl/register_file_if.sv
// Register file interface: one write port and two combinational read ports.
interface register_file_if;
  import cpu_types_pkg::*;

  logic     WEN;
  regbits_t wsel;
  word_t    wdat;
  regbits_t rsel1;
  regbits_t rsel2;
  word_t    rdat1;
  word_t    rdat2;

  modport rf (
    input  WEN, wsel, wdat, rsel1, rsel2,
    output rdat1, rdat2
  );

  modport tb (
    output WEN, wsel, wdat, rsel1, rsel2,
    input  rdat1, rdat2
  );
endinterface

// File: rtl/mips_register_file_rf.sv
// 32 x 32 register array with async active-low clear; register 0 is never written.
module register_file
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  register_file_if.rf rfif
);

  word_t regs_q [NREGS];
  word_t regs_d [NREGS];

  // Writes to register 0 are dropped so it keeps its reset value of zero.
  always_comb begin
    regs_d = regs_q;
    if (rfif.WEN && (rfif.wsel != '0)) begin
      regs_d[rfif.wsel] = rfif.wdat;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rfif.rdat1 = regs_q[rfif.rsel1];
  assign rfif.rdat2 = regs_q[rfif.rsel2];

endmodule

// File: rtl/mips_register_file.sv
// MIPS register file top: flat ports bridged onto register_file_if for the core array.
module mips_register_file
  import cpu_types_pkg::*;
(
  input  logic     CLK,
  input  logic     nRST,
  input  logic     WEN,
  input  regbits_t wsel,
  input  word_t    wdat,
  input  regbits_t rsel1,
  input  regbits_t rsel2,
  output word_t    rdat1,
  output word_t    rdat2
);

  register_file_if rfif ();

  assign rfif.WEN   = WEN;
  assign rfif.wsel  = wsel;
  assign rfif.wdat  = wdat;
  assign rfif.rsel1 = rsel1;
  assign rfif.rsel2 = rsel2;
  assign rdat1      = rfif.rdat1;
  assign rdat2      = rfif.rdat2;

  register_file u_rf (
    .CLK  (CLK),
    .nRST (nRST),
    .rfif (rfif)
  );

endmodule

// File: tb/tb_mips_register_file.sv
// Directed plus randomized bench for mips_register_file against an array reference model.
`timescale 1ns/1ns
module tb_mips_register_file;

  logic        clk;
  logic        nrst;
  logic        wen;
  logic [4:0]  wsel;
  logic [31:0] wdat;
  logic [4:0]  rsel1;
  logic [4:0]  rsel2;
  logic [31:0] rdat1;
  logic [31:0] rdat2;

  logic [31:0] model [32];
  int checks;
  int errors;

  mips_register_file dut (
    .CLK   (clk),
    .nRST  (nrst),
    .WEN   (wen),
    .wsel  (wsel),
    .wdat  (wdat),
    .rsel1 (rsel1),
    .rsel2 (rsel2),
    .rdat1 (rdat1),
    .rdat2 (rdat2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  endtask

  // One write cycle: drive at negedge, commit on posedge, update model after it.
  task automatic wr(input logic w, input logic [4:0] s, input logic [31:0] d);
    @(negedge clk);
    wen  = w;
    wsel = s;
    wdat = d;
    @(posedge clk);
    #1;
    if (w && (s != 5'd0) && nrst) model[s] = d;
    wen = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [4:0] b);
    rsel1 = a;
    rsel2 = b;
    #1;
    check({tag, "_p1"}, rdat1, model[a]);
    check({tag, "_p2"}, rdat2, model[b]);
  endtask

  initial begin
    logic [4:0]  s1, s2;
    logic [31:0] exp_v;
    checks = 0;
    errors = 0;
    nrst  = 1'b0;
    wen   = 1'b0;
    wsel  = 5'd0;
    wdat  = 32'd0;
    rsel1 = 5'd0;
    rsel2 = 5'd0;
    clear_model();

    // Power-on reset reads zero.
    #1;
    rd("por_r0", 5'd0, 5'd31);
    rd("por_r17", 5'd17, 5'd1);
    @(negedge clk);
    nrst = 1'b1;

    // Fill every register with nonzero values, then pulse reset mid-cycle.
    for (int i = 1; i < 32; i++) wr(1'b1, i[4:0], $urandom() | 32'h1);
    rd("fill_chk", 5'd12, 5'd30);
    @(negedge clk);
    #2;
    rsel1 = 5'd12;
    rsel2 = 5'd30;
    nrst  = 1'b0;
    clear_model();
    #1;
    check("rst_immediate_p1", rdat1, 32'd0);
    check("rst_immediate_p2", rdat2, 32'd0);
    for (int i = 0; i < 32; i++) rd("rst_all", i[4:0], 5'(31 - i));

    // A write presented during reset is discarded.
    wr(1'b1, 5'd9, 32'hDEAD_BEEF);
    rd("rst_dominates", 5'd9, 5'd9);
    @(negedge clk);
    nrst = 1'b1;

    // Basic write/read.
    wr(1'b1, 5'd5, 32'd4721);
    rsel1 = 5'd5;
    rsel2 = 5'd5;
    #1;
    check("basic_p1", rdat1, 32'd4721);
    check("basic_p2", rdat2, 32'd4721);

    // Register zero ignores writes.
    wr(1'b1, 5'd0, 32'd25119);
    rsel1 = 5'd0;
    #1;
    check("zero_reg", rdat1, 32'd0);

    // Write enable low leaves the register unchanged.
    wr(1'b1, 5'd7, 32'd1);
    wr(1'b0, 5'd7, 32'd25119);
    rsel1 = 5'd7;
    #1;
    check("wen_low", rdat1, 32'd1);

    // No bypass: old value before the edge, new value after.
    wr(1'b1, 5'd3, 32'd1);
    @(negedge clk);
    wen   = 1'b1;
    wsel  = 5'd3;
    wdat  = 32'd4721;
    rsel1 = 5'd3;
    #1;
    check("nobypass_before", rdat1, 32'd1);
    @(posedge clk);
    #1;
    model[3] = 32'd4721;
    check("nobypass_after", rdat1, 32'd4721);
    wen = 1'b0;

    // Randomized traffic: reads checked just before and just after each edge.
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      wen   = 1'($urandom_range(0, 1));
      wsel  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom());
      wdat  = $urandom();
      s1    = 5'($urandom());
      s2    = ($urandom_range(0, 3) == 0) ? s1 : 5'($urandom());
      rsel1 = s1;
      rsel2 = s2;
      #1;
      check("rand_pre_p1", rdat1, model[s1]);
      check("rand_pre_p2", rdat2, model[s2]);
      @(posedge clk);
      #1;
      if (wen && (wsel != 5'd0)) model[wsel] = wdat;
      check("rand_post_p1", rdat1, model[s1]);
      check("rand_post_p2", rdat2, model[s2]);
    end
    wen = 1'b0;

    // Full sweep with closed-form expectations.
    for (int i = 1; i < 32; i++) wr(1'b1, i[4:0], 32'(i * 3 + 1));
    for (int i = 0; i < 32; i++) begin
      rsel1 = i[4:0];
      rsel2 = 5'(31 - i);
      #1;
      exp_v = (i == 0) ? 32'd0 : 32'(i * 3 + 1);
      check("sweep_p1", rdat1, exp_v);
      exp_v = (i == 31) ? 32'd0 : 32'((31 - i) * 3 + 1);
      check("sweep_p2", rdat2, exp_v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
